// File: rtl/ahb2apb_arb_pkg.sv
// ahb2apb_arb_pkg: shared encodings for the AHB-to-APB requester arbiter
package ahb2apb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} arb_state_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
endpackage

// File: rtl/ahb2apb_arb_picker.sv
// ahb2apb_arb_picker: first requester found searching upward from a start index, wrapping.
// rr=0 pins the start at 0, giving fixed lowest-index priority.
module ahb2apb_arb_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            rr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);
  logic [IW-1:0] start;
  logic [IW-1:0] j;
  assign start = rr ? ptr : '0;
  // Scan from farthest to nearest so the nearest match is written last and wins.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(start) + k) % NREQ);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        grant_idx = j;
      end
    end
  end
endmodule

// File: rtl/ahb2apb_req_arbiter.sv
// ahb2apb_req_arbiter: shares one AHB-Lite bridge slave port among NREQ single-word requesters.
// Define AHB2APB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module ahb2apb_req_arbiter
  import ahb2apb_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DATAWIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      HSEL,
  output logic [ADDRWIDTH-1:0]      HADDR,
  output logic                      HWRITE,
  output logic [DATAWIDTH-1:0]      HWDATA,
  output logic [2:0]                HSIZE,
  output logic [1:0]                HTRANS,
  output logic [3:0]                HPROT,
  output logic                      HREADY,
  input  logic                      HREADYOUT,
  input  logic [DATAWIDTH-1:0]      HRDATA,
  input  logic                      HRESP
);
  localparam int IW = $clog2(NREQ);
  arb_state_t state, state_nxt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] grant_idx, gnt_q, ptr;
  logic [ADDRWIDTH-1:0] addr_q, addr_sel;
  logic [DATAWIDTH-1:0] wdata_q, wdata_sel;
  logic write_q, write_sel, accept, done;
  assign accept = state == IDLE && |req_valid;
  assign done = state == DATA && HREADYOUT;
`ifdef AHB2APB_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
  // ptr is where the next search starts: one past the last winner.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) ptr <= '0;
    else if (accept) ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end
`else
  localparam logic RR_MODE = 1'b0;
  assign ptr = '0;
`endif
  ahb2apb_arb_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req(req_valid), .ptr(ptr), .rr(RR_MODE), .grant(grant), .grant_idx(grant_idx)
  );
  always_comb begin
    addr_sel = '0;
    wdata_sel = '0;
    write_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        addr_sel = req_addr[i*ADDRWIDTH +: ADDRWIDTH];
        wdata_sel = req_wdata[i*DATAWIDTH +: DATAWIDTH];
        write_sel = req_write[i];
      end
    end
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    HSEL = state == ADDR;
    HTRANS = state == ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
    busy = state != IDLE;
    req_ready = accept && !HRESET ? grant : '0;
    if (accept) state_nxt = ADDR;
    else if (state == ADDR && HREADYOUT) state_nxt = DATA;
    else if (done) state_nxt = IDLE;
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      gnt_q <= '0;
      addr_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (accept) begin
        gnt_q <= grant_idx;
        addr_q <= addr_sel;
        write_q <= write_sel;
        wdata_q <= wdata_sel;
      end
      if (done) begin
        rsp_valid[gnt_q] <= 1'b1;
        rsp_rdata <= HRDATA;
        rsp_err <= HRESP;
      end
    end
  end
  assign HADDR = {addr_q[ADDRWIDTH-1:2], 2'b00};
  assign HWRITE = write_q;
  assign HWDATA = wdata_q;
  assign HSIZE = HSIZE_WORD;
  assign HPROT = HPROT_DEFAULT;
  assign HREADY = HREADYOUT;
endmodule

// File: tb/tb_ahb2apb_req_arbiter.sv
// tb_ahb2apb_req_arbiter: scoreboard bench with a behavioural arbiter/bridge model.
// Expected grant order follows AHB2APB_ARB_RR_EN when defined.
module tb_ahb2apb_req_arbiter;
  localparam int NREQ = 4, AW = 16, DW = 32;
  typedef struct { int idx; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wd; } tx_t;
  typedef struct { int idx; logic [DW-1:0] rd; logic err; } rsp_t;

  logic HCLK = 1'b0, HRESET = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata, HWDATA;
  logic [DW-1:0] HRDATA = '0;
  logic rsp_err, busy, HSEL, HWRITE, HREADY;
  logic HREADYOUT = 1'b1, HRESP = 1'b0;
  logic [AW-1:0] HADDR;
  logic [2:0] HSIZE;
  logic [1:0] HTRANS;
  logic [3:0] HPROT;

  ahb2apb_req_arbiter #(.NREQ(NREQ), .ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS), .HPROT(HPROT),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int nchk = 0, npass = 0, cyc = 0, rsp_cnt = 0;
  int last_grant_cyc, last_rsp_cyc, last_addr_cyc;
  logic [AW-1:0] last_haddr;
  logic [DW-1:0] last_rsp_rdata;
  logic last_rsp_err;
  bit m_idle = 1, bdata = 0, use_fix = 0;
  int m_ptr = 0, wcnt = 0, wait_mode = 0, err_mode = 0;
  logic [DW-1:0] fix_rdata = '0;
  logic [NREQ-1:0] acc_mask = '0;
  int rdy_cnt[NREQ];
  int grant_log[$];
  tx_t txq[$];
  rsp_t rspq[$];
  tx_t mt;
  rsp_t mr;
  int mw;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Monitor + bridge model: drives the bridge for the coming edge, then checks.
  always @(negedge HCLK) begin
    if (HRESET) begin
      txq.delete();
      rspq.delete();
      m_idle = 1; m_ptr = 0; bdata = 0; wcnt = 0; acc_mask = '0;
      HREADYOUT = 1'b1; HRESP = 1'b0;
    end else begin
      cyc++;
      HREADYOUT = !bdata || wcnt == 0;
      if (bdata && wcnt > 0) wcnt--;
      HRDATA = use_fix ? fix_rdata : DW'($urandom);
      HRESP = err_mode == 2 ? ($urandom_range(0, 7) == 0) : (err_mode == 1);
      chk("HREADY", HREADY, HREADYOUT);
      if (rsp_valid != '0) begin
        if (rspq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          mr = rspq.pop_front();
          chk("rsp_valid", rsp_valid, 64'(1) << mr.idx);
          chk("rsp_rdata", rsp_rdata, mr.rd);
          chk("rsp_err", rsp_err, mr.err);
          rsp_cnt++;
          last_rsp_cyc = cyc; last_rsp_err = rsp_err; last_rsp_rdata = rsp_rdata;
          m_idle = 1;
        end
      end
      chk("busy", busy, !m_idle);
      if (m_idle && req_valid != '0) begin
        mw = pick(req_valid, m_ptr);
        chk("req_ready", req_ready, 64'(1) << mw);
        mt.idx = mw;
        mt.addr = req_addr[mw*AW +: AW] & ~AW'(3);
        mt.wr = req_write[mw];
        mt.wd = req_wdata[mw*DW +: DW];
        txq.push_back(mt);
        m_idle = 0;
`ifdef AHB2APB_ARB_RR_EN
        m_ptr = (mw + 1) % NREQ;
`endif
        grant_log.push_back(mw);
        last_grant_cyc = cyc;
      end else chk("req_ready_quiet", req_ready, 0);
      acc_mask = req_ready;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (bdata && HREADYOUT) begin
        if (txq.size() > 0) begin
          mt = txq.pop_front();
          if (mt.wr) chk("HWDATA", HWDATA, mt.wd);
          mr.idx = mt.idx; mr.rd = HRDATA; mr.err = HRESP;
          rspq.push_back(mr);
        end
        bdata = 0;
      end else if (HSEL && HTRANS == 2'b10 && HREADYOUT) begin
        if (txq.size() == 0) chk("addr_unexpected", HSEL, 0);
        else begin
          chk("HADDR", HADDR, txq[0].addr);
          chk("HWRITE", HWRITE, txq[0].wr);
          chk("HSIZE", HSIZE, 3'b010);
          chk("HPROT", HPROT, 4'b0011);
          last_addr_cyc = cyc; last_haddr = HADDR;
        end
        bdata = 1;
        wcnt = wait_mode < 0 ? $urandom_range(0, 3) : wait_mode;
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic req(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_rsp(string nm, int maxc);
    int c0 = rsp_cnt;
    for (int k = 0; k < maxc && rsp_cnt == c0; k++) step();
    chk(nm, rsp_cnt, c0 + 1);
  endtask

  task automatic drain(string nm, int maxc);
    for (int k = 0; k < maxc && !(m_idle && txq.size() == 0 && rspq.size() == 0); k++) step();
    chk(nm, m_idle && txq.size() == 0 && rspq.size() == 0, 1);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, rc;
    logic [NREQ-1:0] all_on;
    int exp_rr[5];
    req_valid = '1;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_HSEL", HSEL, 0);
    chk("rst_HTRANS", HTRANS, 0);
    chk("rst_HADDR", HADDR, 0);
    chk("rst_HWRITE", HWRITE, 0);
    chk("rst_HWDATA", HWDATA, 0);
    chk("rst_HSIZE", HSIZE, 3'b010);
    chk("rst_HPROT", HPROT, 4'b0011);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    HRESET = 1'b0;
    step();
    // single write, zero wait
    req(2, 1, 16'h0046, 32'hDEADBEEF);
    wait_rsp("wr_rsp", 20);
    chk("wr_grant", grant_log[$], 2);
    chk("wr_addr_lat", last_addr_cyc - last_grant_cyc, 1);
    chk("wr_haddr", last_haddr, 16'h0044);
    chk("wr_rsp_lat", last_rsp_cyc - last_grant_cyc, 3);
    chk("wr_err", last_rsp_err, 0);
    // read with three wait states in the data phase
    wait_mode = 3; use_fix = 1; fix_rdata = 32'h12345678;
    req(0, 0, 16'h0010, '0);
    wait_rsp("rd_rsp", 30);
    chk("rd_rdata", last_rsp_rdata, 32'h12345678);
    chk("rd_rsp_lat", last_rsp_cyc - last_grant_cyc, 6);
    use_fix = 0; wait_mode = 0;
    // error response, then a clean transfer
    err_mode = 1;
    req(1, 0, 16'h0020, '0);
    wait_rsp("err_rsp", 20);
    chk("err_flag", last_rsp_err, 1);
    err_mode = 0;
    req(1, 1, 16'h0024, 32'hA5A5A5A5);
    wait_rsp("post_err_rsp", 20);
    chk("post_err_flag", last_rsp_err, 0);
    chk("post_err_grant", grant_log[$], 1);
    // withdrawn request while another is served
    wait_mode = 2;
    r1 = rdy_cnt[1];
    req(3, 0, 16'h0030, '0);
    step();
    req(1, 1, 16'h0034, 32'h11112222);
    step();
    req_valid[1] = 1'b0;
    wait_rsp("wd_rsp", 30);
    repeat (4) step();
    chk("wd_no_ready1", rdy_cnt[1], r1);
    chk("wd_grant3", grant_log[$], 3);
    wait_mode = 0;
    // reset during the address phase
    req(2, 0, 16'h0040, '0);
    step();
    chk("pre_rst_HSEL", HSEL, 1);
    rc = rsp_cnt;
    HRESET = 1'b1;
    #1;
    chk("midrst_HSEL", HSEL, 0);
    chk("midrst_HTRANS", HTRANS, 0);
    chk("midrst_busy", busy, 0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    repeat (5) step();
    chk("midrst_no_rsp", rsp_cnt, rc);
    grant_log.delete();
    req(0, 0, 16'h0050, '0);
    req(3, 1, 16'h0054, 32'hCAFEF00D);
    wait_rsp("postrst_rsp", 20);
    chk("postrst_grant0", grant_log[0], 0);
    chk("b2b_grant_same_cycle", last_grant_cyc, last_rsp_cyc);
    drain("postrst_drain", 30);
    // contention: all requesters continuously valid
    do_reset();
    grant_log.delete();
    all_on = '1;
    for (int i = 0; i < NREQ; i++) req(i, $urandom_range(0, 1), AW'($urandom), DW'($urandom));
    for (int k = 0; k < 80; k++) begin
      step();
      if (grant_log.size() >= 5) break;
      for (int i = 0; i < NREQ; i++)
        if (all_on[i] && !req_valid[i]) req(i, $urandom_range(0, 1), AW'($urandom), DW'($urandom));
    end
    req_valid = '0;
    drain("cont_drain", 30);
    chk("cont_count", grant_log.size() >= 5, 1);
`ifdef AHB2APB_ARB_RR_EN
    exp_rr = '{0, 1, 2, 3, 0};
`else
    exp_rr = '{0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk($sformatf("cont_grant%0d", k), grant_log[k], exp_rr[k]);
    // randomized traffic with waits, errors and withdrawals
    wait_mode = -1; err_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) req(i, $urandom_range(0, 1), AW'($urandom), DW'($urandom));
        else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    drain("rand_drain", 50);
    chk("rand_txq_empty", txq.size(), 0);
    chk("rand_rspq_empty", rspq.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
